// File: rtl/rv32_datapath_core.sv
// rv32_datapath_core
//   Execution datapath for a single-cycle RV32I CPU. It contains:
//     - a NREGS x XLEN register file with combinational reads and a
//       clocked write. Register 0 reads as zero.
//     - a combinational integer ALU. Operand A is the rs1 read value.
//     - a 4-register memory-mapped timer peripheral.
//
// Ports
//   clk, reset             clock; synchronous active-high reset
//   rs1, rs2, rd           register read indices and write index
//   regwrite, rf_indata    register write enable and write data
//   rv1, rv2, x031         read values of rs1 and rs2, and a debug copy of x31
//   op, in2, shamt         ALU opcode, operand B and immediate shift amount
//   out, x31               ALU result and exception code (1 = bad opcode)
//   ce, we, addr, wdata    timer chip enable, write enable, register select
//                          and write data
//   rdata                  timer read data
module rv32_datapath_core #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    // register file
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [4:0]      rd,
    input  logic            regwrite,
    input  logic [XLEN-1:0] rf_indata,
    output logic [XLEN-1:0] rv1,
    output logic [XLEN-1:0] rv2,
    output logic [XLEN-1:0] x031,
    // ALU
    input  logic [5:0]      op,
    input  logic [XLEN-1:0] in2,
    input  logic [4:0]      shamt,
    output logic [XLEN-1:0] out,
    output logic [XLEN-1:0] x31,
    // timer peripheral
    input  logic            ce,
    input  logic            we,
    input  logic [1:0]      addr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata
);

    localparam logic [5:0] OP_ADDI  = 6'd0;
    localparam logic [5:0] OP_SLTI  = 6'd1;
    localparam logic [5:0] OP_SLTIU = 6'd2;
    localparam logic [5:0] OP_XORI  = 6'd3;
    localparam logic [5:0] OP_ORI   = 6'd4;
    localparam logic [5:0] OP_ANDI  = 6'd5;
    localparam logic [5:0] OP_SLLI  = 6'd6;
    localparam logic [5:0] OP_SRLI  = 6'd7;
    localparam logic [5:0] OP_SRAI  = 6'd8;
    localparam logic [5:0] OP_ADD   = 6'd9;
    localparam logic [5:0] OP_SUB   = 6'd10;
    localparam logic [5:0] OP_SLL   = 6'd11;
    localparam logic [5:0] OP_SLT   = 6'd12;
    localparam logic [5:0] OP_SLTU  = 6'd13;
    localparam logic [5:0] OP_XOR   = 6'd14;
    localparam logic [5:0] OP_SRL   = 6'd15;
    localparam logic [5:0] OP_SRA   = 6'd16;
    localparam logic [5:0] OP_OR    = 6'd17;
    localparam logic [5:0] OP_AND   = 6'd18;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_LIMIT  = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [XLEN-1:0] rf_q [NREGS];
    logic [XLEN-1:0] rf_d [NREGS];

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            rf_d[i] = rf_q[i];
        end
        if (regwrite && (rd != 5'd0)) begin
            rf_d[rd] = rf_indata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    // Reads come straight from the flops, so a write is only visible
    // after its edge (no bypass).
    assign rv1  = (rs1 == 5'd0) ? '0 : rf_q[rs1];
    assign rv2  = (rs2 == 5'd0) ? '0 : rf_q[rs2];
    assign x031 = rf_q[NREGS-1];

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;
    logic signed [XLEN-1:0] imm_s;
    logic        [XLEN-1:0] imm_u;

    assign a_s   = $signed(rv1);
    assign b_s   = $signed(in2);
    assign imm_s = $signed({{(XLEN-12){in2[11]}}, in2[11:0]});
    assign imm_u = $unsigned(imm_s);

    always_comb begin
        out = '0;
        x31 = '0;
        if (!reset) begin
            case (op)
                OP_ADDI:  out = rv1 + imm_u;
                OP_SLTI:  out = {{(XLEN-1){1'b0}}, (a_s < imm_s)};
                OP_SLTIU: out = {{(XLEN-1){1'b0}}, (rv1 < imm_u)};
                OP_XORI:  out = rv1 ^ imm_u;
                OP_ORI:   out = rv1 | imm_u;
                OP_ANDI:  out = rv1 & imm_u;
                OP_SLLI:  out = rv1 << shamt;
                OP_SRLI:  out = rv1 >> shamt;
                OP_SRAI:  out = $unsigned(a_s >>> shamt);
                OP_ADD:   out = rv1 + in2;
                OP_SUB:   out = rv1 - in2;
                OP_SLL:   out = rv1 << in2[4:0];
                OP_SLT:   out = {{(XLEN-1){1'b0}}, (a_s < b_s)};
                OP_SLTU:  out = {{(XLEN-1){1'b0}}, (rv1 < in2)};
                OP_XOR:   out = rv1 ^ in2;
                OP_SRL:   out = rv1 >> in2[4:0];
                OP_SRA:   out = $unsigned(a_s >>> in2[4:0]);
                OP_OR:    out = rv1 | in2;
                OP_AND:   out = rv1 & in2;
                default:  x31 = {{(XLEN-1){1'b0}}, 1'b1};
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Timer peripheral
    // ------------------------------------------------------------------
    logic [XLEN-1:0] limit_q, limit_d;
    logic [XLEN-1:0] count_q, count_d;
    logic            done_q,  done_d;
    logic            run_q,   run_d;
    logic [XLEN-1:0] count_inc;
    logic            wr_en;

    assign wr_en     = ce && we;
    assign count_inc = count_q + 1'b1;

    always_comb begin
        limit_d = limit_q;
        count_d = count_q;
        done_d  = done_q;
        run_d   = run_q;

        if (wr_en && (addr == A_LIMIT)) begin
            limit_d = wdata;
        end

        // A CTRL write restarts the timer and overrides a done event in
        // the same cycle.
        if (wr_en && (addr == A_CTRL)) begin
            count_d = '0;
            done_d  = 1'b0;
            run_d   = 1'b1;
        end else if (run_q) begin
            if (count_q == limit_q) begin
                // Already at the limit (e.g. LIMIT=0 at start): stop and hold.
                done_d = 1'b1;
                run_d  = 1'b0;
            end else begin
                // Flag done on the edge where COUNT reaches LIMIT, so STATUS
                // becomes visible in the same cycle COUNT reads LIMIT.
                count_d = count_inc;
                if (count_inc == limit_q) begin
                    done_d = 1'b1;
                    run_d  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            limit_q <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            limit_q <= limit_d;
            count_q <= count_d;
            done_q  <= done_d;
            run_q   <= run_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (ce && !we) begin
            case (addr)
                A_LIMIT:  rdata = limit_q;
                A_COUNT:  rdata = count_q;
                A_STATUS: rdata = {{(XLEN-1){1'b0}}, done_q};
                default:  rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_datapath_core.sv
module tb_rv32_datapath_core;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs1, rs2, rd;
    logic        regwrite;
    logic [31:0] rf_indata;
    logic [31:0] rv1, rv2, x031;
    logic [5:0]  op;
    logic [31:0] in2;
    logic [4:0]  shamt;
    logic [31:0] out, x31;
    logic        ce, we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    int n_total = 0;
    int n_pass  = 0;

    rv32_datapath_core #(.XLEN(32), .NREGS(32)) dut (
        .clk(clk), .reset(reset),
        .rs1(rs1), .rs2(rs2), .rd(rd), .regwrite(regwrite), .rf_indata(rf_indata),
        .rv1(rv1), .rv2(rv2), .x031(x031),
        .op(op), .in2(in2), .shamt(shamt), .out(out), .x31(x31),
        .ce(ce), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] exp_out;
        logic [31:0] exp_x31;
    } alu_vec_t;

    alu_vec_t vecs [22];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] idx, input logic [31:0] val);
        regwrite  = 1'b1;
        rd        = idx;
        rf_indata = val;
        tick();
        regwrite  = 1'b0;
    endtask

    task automatic per_write(input logic [1:0] a, input logic [31:0] d);
        ce = 1'b1; we = 1'b1; addr = a; wdata = d;
        tick();
        ce = 1'b0; we = 1'b0;
    endtask

    task automatic per_read(input logic [1:0] a, output logic [31:0] d);
        ce = 1'b1; we = 1'b0; addr = a;
        #1;
        d = rdata;
        ce = 1'b0;
    endtask

    logic [31:0] rd_val;

    initial begin
        reset = 1'b1; rs1 = '0; rs2 = '0; rd = '0; regwrite = 1'b0; rf_indata = '0;
        op = 6'd0; in2 = '0; shamt = '0; ce = 1'b0; we = 1'b0; addr = '0; wdata = '0;

        //             op     A             B             sh     out           x31
        vecs[0]  = '{6'd9,  32'hFFFFFFFF, 32'h00000001, 5'd7,  32'h00000000, 32'd0};
        vecs[1]  = '{6'd10, 32'h00000000, 32'h00000001, 5'd7,  32'hFFFFFFFF, 32'd0};
        vecs[2]  = '{6'd0,  32'h00000005, 32'h00000FFF, 5'd7,  32'h00000004, 32'd0};
        vecs[3]  = '{6'd12, 32'h80000000, 32'h00000001, 5'd7,  32'h00000001, 32'd0};
        vecs[4]  = '{6'd13, 32'h80000000, 32'h00000001, 5'd7,  32'h00000000, 32'd0};
        vecs[5]  = '{6'd8,  32'h80000000, 32'h00000001, 5'd4,  32'hF8000000, 32'd0};
        vecs[6]  = '{6'd7,  32'h80000000, 32'h00000001, 5'd4,  32'h08000000, 32'd0};
        vecs[7]  = '{6'd11, 32'h00000003, 32'd33,       5'd7,  32'h00000006, 32'd0};
        vecs[8]  = '{6'd25, 32'h12345678, 32'h00000001, 5'd7,  32'h00000000, 32'd1};
        vecs[9]  = '{6'd18, 32'hF0F0F0F0, 32'hFF00FF00, 5'd7,  32'hF000F000, 32'd0};
        vecs[10] = '{6'd1,  32'hFFFFFFFF, 32'h00000001, 5'd7,  32'h00000001, 32'd0};
        vecs[11] = '{6'd2,  32'h00000005, 32'h00000FFF, 5'd7,  32'h00000001, 32'd0};
        vecs[12] = '{6'd3,  32'h0000FFFF, 32'h00000800, 5'd7,  32'hFFFF07FF, 32'd0};
        vecs[13] = '{6'd4,  32'h00000010, 32'h0000000F, 5'd7,  32'h0000001F, 32'd0};
        vecs[14] = '{6'd5,  32'h12345678, 32'hFFFFF0FF, 5'd7,  32'h00000078, 32'd0};
        vecs[15] = '{6'd6,  32'h00000001, 32'h00000000, 5'd31, 32'h80000000, 32'd0};
        vecs[16] = '{6'd14, 32'hAAAAAAAA, 32'hFFFFFFFF, 5'd7,  32'h55555555, 32'd0};
        vecs[17] = '{6'd15, 32'h80000000, 32'h00000024, 5'd7,  32'h08000000, 32'd0};
        vecs[18] = '{6'd16, 32'h80000000, 32'h0000001F, 5'd7,  32'hFFFFFFFF, 32'd0};
        vecs[19] = '{6'd17, 32'h0000000F, 32'h000000F0, 5'd7,  32'h000000FF, 32'd0};
        vecs[20] = '{6'd63, 32'h00000001, 32'h00000001, 5'd7,  32'h00000000, 32'd1};
        vecs[21] = '{6'd19, 32'h00000001, 32'h00000001, 5'd7,  32'h00000000, 32'd1};

        tick();
        tick();
        reset = 1'b0;

        // Reset state
        rs1 = 5'd5; rs2 = 5'd31;
        #1;
        check("rst_rv1", rv1, 32'h0);
        check("rst_x031", x031, 32'h0);
        per_read(2'd1, rd_val); check("rst_limit", rd_val, 32'h0);
        per_read(2'd2, rd_val); check("rst_count", rd_val, 32'h0);
        per_read(2'd3, rd_val); check("rst_status", rd_val, 32'h0);

        // Register file: no bypass, then visible after the edge
        regwrite = 1'b1; rd = 5'd5; rf_indata = 32'hDEADBEEF; rs1 = 5'd5;
        #1;
        check("rf_nobypass", rv1, 32'h0);
        tick();
        regwrite = 1'b0;
        check("rf_write5", rv1, 32'hDEADBEEF);
        write_reg(5'd0, 32'h00001234);
        rs1 = 5'd0; #1;
        check("rf_x0_zero", rv1, 32'h0);
        write_reg(5'd31, 32'h00000055);
        rs2 = 5'd31; #1;
        check("rf_x031", x031, 32'h55);
        check("rf_rv2_31", rv2, 32'h55);
        write_reg(5'd6, 32'h00000000);
        rs2 = 5'd5; #1;
        check("rf_rv2_5", rv2, 32'hDEADBEEF);

        // ALU vectors: operand A loaded through register 1
        for (int i = 0; i < 22; i++) begin
            write_reg(5'd1, vecs[i].a);
            rs1 = 5'd1; op = vecs[i].op; in2 = vecs[i].b; shamt = vecs[i].sh;
            #1;
            check($sformatf("alu_out[%0d]", i), out, vecs[i].exp_out);
            check($sformatf("alu_x31[%0d]", i), x31, vecs[i].exp_x31);
        end

        // Timer: LIMIT=3 then start; COUNT 1,2,3 then hold, STATUS from 3
        per_write(2'd1, 32'd3);
        per_read(2'd1, rd_val); check("tmr_limit", rd_val, 32'd3);
        per_write(2'd0, 32'hFFFF_FFFF);
        per_read(2'd2, rd_val); check("tmr_count_start", rd_val, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            per_read(2'd2, rd_val);
            check($sformatf("tmr_count_c%0d", k), rd_val, (k >= 3) ? 32'd3 : k);
            per_read(2'd3, rd_val);
            check($sformatf("tmr_status_c%0d", k), rd_val, (k >= 3) ? 32'd1 : 32'd0);
        end
        ce = 1'b0; we = 1'b0; addr = 2'd2; #1;
        check("tmr_ce0", rdata, 32'h0);
        per_read(2'd0, rd_val); check("tmr_ctrl_read", rd_val, 32'h0);
        per_write(2'd2, 32'h99);
        per_write(2'd3, 32'h0);
        per_read(2'd2, rd_val); check("tmr_count_ro", rd_val, 32'd3);
        per_read(2'd3, rd_val); check("tmr_status_ro", rd_val, 32'd1);

        // LIMIT=0: STATUS on the first edge after start, COUNT stays 0
        per_write(2'd1, 32'd0);
        per_write(2'd0, 32'd0);
        per_read(2'd3, rd_val); check("tmr_l0_status0", rd_val, 32'd0);
        tick();
        per_read(2'd3, rd_val); check("tmr_l0_status1", rd_val, 32'd1);
        per_read(2'd2, rd_val); check("tmr_l0_count", rd_val, 32'd0);

        // CTRL write in the same cycle as the done condition wins
        per_write(2'd1, 32'd2);
        per_write(2'd0, 32'd0);
        tick();
        per_read(2'd2, rd_val); check("tmr_pre_done", rd_val, 32'd1);
        per_write(2'd0, 32'd0);
        per_read(2'd2, rd_val); check("tmr_restart_cnt", rd_val, 32'd0);
        per_read(2'd3, rd_val); check("tmr_restart_st", rd_val, 32'd0);
        tick();
        per_read(2'd2, rd_val); check("tmr_restart_run", rd_val, 32'd1);

        // Reset mid-operation
        per_write(2'd1, 32'd10);
        per_write(2'd0, 32'd0);
        tick();
        write_reg(5'd7, 32'h77);
        reset = 1'b1;
        regwrite = 1'b1; rd = 5'd7; rf_indata = 32'hABCD;
        ce = 1'b1; we = 1'b1; addr = 2'd1; wdata = 32'd5;
        op = 6'd25; rs1 = 5'd7;
        #1;
        check("rst_alu_out", out, 32'h0);
        check("rst_alu_x31", x31, 32'h0);
        tick();
        reset = 1'b0; regwrite = 1'b0; ce = 1'b0; we = 1'b0;
        #1;
        check("rstm_rv1", rv1, 32'h0);
        check("rstm_x031", x031, 32'h0);
        per_read(2'd1, rd_val); check("rstm_limit", rd_val, 32'h0);
        per_read(2'd2, rd_val); check("rstm_count", rd_val, 32'h0);
        per_read(2'd3, rd_val); check("rstm_status", rd_val, 32'h0);
        tick(); tick(); tick();
        per_read(2'd2, rd_val); check("rstm_stopped", rd_val, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
